// File: rtl/mac_flex_pkg.sv
// Shared encodings, drain FSM states and the saturating adder for the mac_row_flex row.
// sat_add is only called when MAC_ROW_SAT_EN is defined.
package mac_flex_pkg;

  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;
  localparam logic [1:0] INST_CLR  = 2'b11;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_DRAIN
  } drain_state_e;

  // Operands arrive sign-extended to 32 bits; the result is clamped to a w-bit signed range.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    longint s;
    longint hi;
    longint lo;
    s  = longint'(a) + longint'(b);
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (s > hi) return 32'(hi);
    if (s < lo) return 32'(lo);
    return 32'(s);
  endfunction

endpackage

// File: rtl/mac_row_flex_tile.sv
// One WS/OS MAC tile: forwarding registers, stationary weight, OS accumulator.
// MAC_ROW_SAT_EN selects saturating instead of wrapping psum/acc additions.
module mac_tile_flex
  import mac_flex_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic                      acc_freeze,
  input  logic                      acc_clr,
  input  logic signed [bw-1:0]      act_in,
  input  logic [1:0]                inst_in,
  input  logic signed [psum_bw-1:0] in_n,
  output logic signed [bw-1:0]      act_out,
  output logic [1:0]                inst_out,
  output logic signed [psum_bw-1:0] out_s,
  output logic                      valid,
  output logic signed [psum_bw-1:0] acc
);

  logic signed [bw-1:0]      act_q;
  logic signed [bw-1:0]      weight_q;
  logic signed [bw-1:0]      w_sel;
  logic [1:0]                inst_q;
  logic                      loaded_q;
  logic                      capture;
  logic signed [2*bw-1:0]    prod;
  logic signed [psum_bw-1:0] prod_ext;
  logic signed [psum_bw-1:0] acc_q;
  logic signed [psum_bw-1:0] out_s_q;
  logic                      valid_q;

  function automatic logic signed [psum_bw-1:0] psum_add(input logic signed [psum_bw-1:0] a,
                                                         input logic signed [psum_bw-1:0] b);
`ifdef MAC_ROW_SAT_EN
    return psum_bw'(sat_add(32'(a), 32'(b), psum_bw));
`else
    return a + b;
`endif
  endfunction

  // A LOAD captured here is swallowed so the next unloaded tile east gets the next weight.
  assign capture  = (inst_q == INST_LOAD) && !loaded_q;
  assign act_out  = act_q;
  assign inst_out = capture ? INST_NOP : inst_q;

  assign w_sel    = (mode == MODE_OS) ? $signed(in_n[bw-1:0]) : weight_q;
  assign prod     = (2*bw)'(act_q) * (2*bw)'(w_sel);
  assign prod_ext = psum_bw'(prod);

  assign out_s = out_s_q;
  assign valid = valid_q;
  assign acc   = acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_q    <= '0;
      inst_q   <= INST_NOP;
      weight_q <= '0;
      loaded_q <= 1'b0;
      acc_q    <= '0;
      out_s_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      act_q   <= act_in;
      inst_q  <= inst_in;
      valid_q <= 1'b0;
      case (inst_q)
        INST_LOAD: begin
          if (capture) begin
            weight_q <= act_q;
            loaded_q <= 1'b1;
          end
        end
        INST_EXEC: begin
          valid_q <= 1'b1;
          if (mode == MODE_OS) begin
            out_s_q <= in_n;
            if (!acc_freeze) acc_q <= psum_add(acc_q, prod_ext);
          end else begin
            out_s_q <= psum_add(in_n, prod_ext);
          end
        end
        INST_CLR: begin
          weight_q <= '0;
          loaded_q <= 1'b0;
          if (!acc_freeze) acc_q <= '0;
        end
        default: ;
      endcase
      // The final drain handshake wipes the accumulator even though the row is frozen.
      if (acc_clr) acc_q <= '0;
    end
  end

endmodule

// File: rtl/mac_row_flex.sv
// Row of col MAC tiles with west-to-east instruction ripple and an OS drain FSM.
// MAC_ROW_SAT_EN (optional) makes every tile's additions saturate.
module mac_row_flex
  import mac_flex_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int col     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [bw-1:0]      in_w,
  input  logic [1:0]                inst_w,
  input  logic [psum_bw*col-1:0]    in_n,
  input  logic                      mode,
  output logic [psum_bw*col-1:0]    out_s,
  output logic [col-1:0]            valid,
  input  logic                      drain_req,
  output logic [psum_bw-1:0]        drain_data,
  output logic [$clog2(col)-1:0]    drain_col,
  output logic                      drain_valid,
  input  logic                      drain_ready,
  output logic                      busy
);

  localparam int cw = $clog2(col);
  localparam logic [cw-1:0] last_col = cw'(col - 1);

  logic signed [bw-1:0]      act_link  [0:col];
  logic [1:0]                inst_link [0:col];
  logic signed [psum_bw-1:0] acc_arr   [0:col-1];
  logic [bw+1:0]             unused_east;

  drain_state_e  state_q, state_d;
  logic [cw-1:0] col_q, col_d;
  logic          acc_clr;

  assign act_link[0]  = in_w;
  assign inst_link[0] = inst_w;
  assign unused_east  = {act_link[col], inst_link[col]};

  for (genvar i = 0; i < col; i++) begin : g_tile
    mac_tile_flex #(
      .bw      (bw),
      .psum_bw (psum_bw)
    ) u_tile (
      .clk        (clk),
      .reset      (reset),
      .mode       (mode),
      .acc_freeze (busy),
      .acc_clr    (acc_clr),
      .act_in     (act_link[i]),
      .inst_in    (inst_link[i]),
      .in_n       (in_n[i*psum_bw +: psum_bw]),
      .act_out    (act_link[i+1]),
      .inst_out   (inst_link[i+1]),
      .out_s      (out_s[i*psum_bw +: psum_bw]),
      .valid      (valid[i]),
      .acc        (acc_arr[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
    end
  end

  // Drain requests only start from IDLE in OS mode; the last accepted word clears every acc.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    acc_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (drain_req && (mode == MODE_OS)) begin
          state_d = ST_DRAIN;
          col_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_ready) begin
          if (col_q == last_col) begin
            state_d = ST_IDLE;
            col_d   = '0;
            acc_clr = 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy        = (state_q == ST_DRAIN);
  assign drain_valid = busy;
  assign drain_col   = col_q;
  assign drain_data  = busy ? acc_arr[col_q] : '0;

endmodule

// File: tb/tb_mac_row_flex.sv
// Randomized self-checking bench for mac_row_flex against a transaction-level row model.
// Honours MAC_ROW_SAT_EN for the overflow expectation.
module tb_mac_row_flex;

  localparam int COL = 8;
  localparam int BW  = 4;
  localparam int PW  = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [BW-1:0] in_w;
  logic [1:0]           inst_w;
  logic [PW*COL-1:0]    in_n;
  logic                 mode;
  logic [PW*COL-1:0]    out_s;
  logic [COL-1:0]       valid;
  logic                 drain_req;
  logic [PW-1:0]        drain_data;
  logic [2:0]           drain_col;
  logic                 drain_valid;
  logic                 drain_ready;
  logic                 busy;

  mac_row_flex #(.bw(BW), .psum_bw(PW), .col(COL)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_w        (in_w),
    .inst_w      (inst_w),
    .in_n        (in_n),
    .mode        (mode),
    .out_s       (out_s),
    .valid       (valid),
    .drain_req   (drain_req),
    .drain_data  (drain_data),
    .drain_col   (drain_col),
    .drain_valid (drain_valid),
    .drain_ready (drain_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Row model: in-flight instructions walk one tile per edge; each tile keeps architectural state.
  typedef struct {logic [1:0] inst; int act; int pos;} item_t;
  typedef struct {int col; logic [PW-1:0] data;} word_t;

  item_t         inflight[$];
  word_t         words[$];
  logic [PW-1:0] m_out [COL];
  logic [PW-1:0] m_acc [COL];
  int            m_w   [COL];
  bit            m_loaded [COL];
  logic [COL-1:0] m_valid;
  bit            m_busy;
  int            m_col;
  logic [PW-1:0] last_data;
  int            last_col;
  logic          last_valid;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] add16(input logic [PW-1:0] a, input int p);
    int s;
    s = int'($signed(a)) + p;
`ifdef MAC_ROW_SAT_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    return 16'(s);
  endfunction

  task automatic model_reset();
    inflight.delete();
    for (int i = 0; i < COL; i++) begin
      m_out[i] = '0; m_acc[i] = '0; m_w[i] = 0; m_loaded[i] = 0;
    end
    m_valid = '0; m_busy = 0; m_col = 0;
    last_valid = 0; last_data = '0; last_col = 0;
  endtask

  task automatic model_edge();
    bit freeze, fin, keep;
    item_t nxt[$];
    item_t it;
    int p, wos;
    if (reset) begin
      model_reset();
      return;
    end
    freeze = m_busy;
    fin    = m_busy && drain_ready && (m_col == COL - 1);
    if (last_valid && drain_ready) words.push_back('{last_col, last_data});
    m_valid = '0;
    foreach (inflight[k]) begin
      it = inflight[k];
      p = it.pos;
      keep = 1;
      case (it.inst)
        2'b01: if (!m_loaded[p]) begin m_w[p] = it.act; m_loaded[p] = 1; keep = 0; end
        2'b10: begin
          m_valid[p] = 1'b1;
          if (mode) begin
            m_out[p] = in_n[p*PW +: PW];
            wos = $signed(in_n[p*PW +: BW]);
            if (!freeze) m_acc[p] = add16(m_acc[p], it.act * wos);
          end else begin
            m_out[p] = add16(in_n[p*PW +: PW], it.act * m_w[p]);
          end
        end
        2'b11: begin m_w[p] = 0; m_loaded[p] = 0; if (!freeze) m_acc[p] = '0; end
        default: ;
      endcase
      if (keep && p + 1 < COL) begin it.pos = p + 1; nxt.push_back(it); end
    end
    inflight = nxt;
    if (inst_w != 2'b00) inflight.push_back('{inst_w, int'(in_w), 0});
    if (fin) for (int i = 0; i < COL; i++) m_acc[i] = '0;
    if (!m_busy) begin
      if (drain_req && mode) begin m_busy = 1; m_col = 0; end
    end else if (drain_ready) begin
      if (m_col == COL - 1) begin m_busy = 0; m_col = 0; end
      else m_col++;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < COL; i++)
      check_output($sformatf("out_s[%0d]", i), 32'(out_s[i*PW +: PW]), 32'(m_out[i]));
    check_output("valid", 32'(valid), 32'(m_valid));
    check_output("busy", 32'(busy), 32'(m_busy));
    check_output("drain_valid", 32'(drain_valid), 32'(m_busy));
    check_output("drain_col", 32'(drain_col), 32'(m_col));
    check_output("drain_data", 32'(drain_data), m_busy ? 32'(m_acc[m_col]) : 32'd0);
    last_data  = drain_data;
    last_col   = int'(drain_col);
    last_valid = drain_valid;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic apply_stimulus(input logic [1:0] inst, input logic signed [BW-1:0] act);
    inst_w = inst;
    in_w   = act;
    step();
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(2'b00, 4'sd0);
  endtask

  task automatic drain_until_idle(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (busy && cycles < budget) begin
      apply_stimulus(2'b00, 4'sd0);
      cycles++;
    end
    check_output({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic start_drain();
    words.delete();
    drain_req = 1'b1;
    apply_stimulus(2'b00, 4'sd0);
    drain_req = 1'b0;
  endtask

  task automatic check_words(input string tag, input logic [PW-1:0] exp);
    check_output({tag, "_count"}, 32'(words.size()), 32'(COL));
    foreach (words[k]) begin
      check_output($sformatf("%s_col%0d", tag, k), 32'(words[k].col), 32'(k));
      check_output($sformatf("%s_data%0d", tag, k), 32'(words[k].data), 32'(exp));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int w_ws [COL];
    int cyc;
    logic signed [BW-1:0] r;
    logic [PW-1:0] snap [COL];
    logic [PW-1:0] ovf_exp;

    w_ws = '{1, 2, 3, 4, 5, 6, 7, -1};
    reset = 1'b1; in_w = '0; inst_w = 2'b00; in_n = '0; mode = 1'b0;
    drain_req = 1'b0; drain_ready = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(posedge clk); #1 reset = 1'b0;
    $display("[TB] reset released");

    // WS weight load and execute
    in_n = {COL{16'd10}};
    for (int i = 0; i < COL; i++) apply_stimulus(2'b01, BW'(w_ws[i]));
    apply_stimulus(2'b10, 4'sd2);
    nops(COL);
    for (int i = 0; i < COL; i++)
      check_output($sformatf("ws_res%0d", i), 32'(out_s[i*PW +: PW]), 32'(16'(10 + 2 * w_ws[i])));

    // CLR wipes the weights, then reloading works
    apply_stimulus(2'b11, 4'sd0);
    nops(COL);
    apply_stimulus(2'b10, 4'sd5);
    nops(COL);
    for (int i = 0; i < COL; i++)
      check_output($sformatf("clr_res%0d", i), 32'(out_s[i*PW +: PW]), 32'd10);
    for (int i = 0; i < COL; i++) begin r = 4'($urandom); apply_stimulus(2'b01, r); end
    apply_stimulus(2'b10, 4'sd1);
    nops(COL);

    // Random WS traffic
    for (int i = 0; i < 200; i++) begin
      in_n = {$urandom, $urandom, $urandom, $urandom};
      r = 4'($urandom);
      apply_stimulus(2'($urandom), r);
    end
    nops(COL);
    mode = 1'b1;

    // OS accumulate and drain
    in_n = {COL{16'h0002}};
    apply_stimulus(2'b11, 4'sd0);
    nops(COL);
    for (int i = 0; i < 4; i++) apply_stimulus(2'b10, 4'sd3);
    nops(COL);
    drain_ready = 1'b1;
    start_drain();
    drain_until_idle("os_drain", 20, cyc);
    check_output("os_drain_cycles", 32'(cyc), 32'(COL));
    check_words("os_word", 16'd24);
    start_drain();
    drain_until_idle("os_drain2", 20, cyc);
    check_words("os_zero", 16'd0);

    // Backpressure drain
    for (int i = 0; i < 20; i++) begin
      in_n = {$urandom, $urandom, $urandom, $urandom};
      r = 4'($urandom);
      apply_stimulus(2'b10, r);
    end
    nops(COL);
    for (int i = 0; i < COL; i++) snap[i] = m_acc[i];
    drain_ready = 1'b0;
    start_drain();
    cyc = 0;
    while (busy && cyc < 40) begin
      drain_ready = ~drain_ready;
      apply_stimulus(2'b00, 4'sd0);
      cyc++;
    end
    check_output("bp_idle", 32'(busy), 32'd0);
    check_output("bp_count", 32'(words.size()), 32'(COL));
    foreach (words[k]) begin
      check_output($sformatf("bp_col%0d", k), 32'(words[k].col), 32'(k));
      check_output($sformatf("bp_data%0d", k), 32'(words[k].data), 32'(snap[k]));
    end

    // Random OS traffic with random drains and backpressure
    for (int i = 0; i < 300; i++) begin
      in_n = {$urandom, $urandom, $urandom, $urandom};
      drain_req   = ($urandom_range(0, 7) == 0);
      drain_ready = 1'($urandom);
      r = 4'($urandom);
      apply_stimulus(2'($urandom), r);
    end
    drain_req = 1'b0;
    drain_ready = 1'b1;
    drain_until_idle("rnd_os", 20, cyc);

    // Accumulator overflow
    in_n = {COL{16'h0007}};
    apply_stimulus(2'b11, 4'sd0);
    nops(COL);
    for (int i = 0; i < 700; i++) apply_stimulus(2'b10, 4'sd7);
    nops(COL);
`ifdef MAC_ROW_SAT_EN
    ovf_exp = 16'h7FFF;
`else
    ovf_exp = 16'h85FC;
`endif
    start_drain();
    drain_until_idle("ovf", 20, cyc);
    check_words("ovf", ovf_exp);

    // Reset in the middle of a drain
    in_n = {COL{16'h0001}};
    for (int i = 0; i < 3; i++) apply_stimulus(2'b10, 4'sd5);
    nops(COL);
    start_drain();
    cyc = 0;
    while (drain_col != 3'd3 && cyc < 10) begin
      apply_stimulus(2'b00, 4'sd0);
      cyc++;
    end
    check_output("abort_col", 32'(drain_col), 32'd3);
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check_output("abort_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b0;
    start_drain();
    drain_until_idle("post_abort", 20, cyc);
    check_words("post_abort", 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_row_flex.md
# mac_row_flex

Parametrised row of `col` signed MAC tiles for the systolic array, the successor to the fixed 8-column row. It supports weight-stationary (WS) and output-stationary (OS) dataflow. Activations and instructions ripple west-to-east one tile per cycle. In OS mode, a per-row drain FSM serialises the column accumulators to the output collector over a valid/ready handshake.

## Interface
- `bw`, 4, activation/weight width (signed)
- `psum_bw`, 16, partial-sum/accumulator width (signed)
- `col`, 8, number of tiles in the row (≥2)

- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-high reset
- `in_w`  input  bw  activation entering tile 0
- `inst_w`  input  2  instruction entering tile 0: 00 NOP, 01 LOAD, 10 EXEC, 11 CLR
- `in_n`  input  psum_bw*col  per-column north input: WS psum-in; OS weight in low `bw` bits
- `mode`  input  1  0 = WS, 1 = OS
- `out_s`  output  psum_bw*col  per-column south output
- `valid`  output  col  per-column `out_s` qualifier
- `drain_req`  input  1  start-drain request (OS only)
- `drain_data`  output  psum_bw  drained accumulator
- `drain_col`  output  $clog2(col)  column index of `drain_data`
- `drain_valid`  output  1  drain word valid
- `drain_ready`  input  1  consumer accepts word
- `busy`  output  1  drain in progress

## Operation
- Tile i registers activation and instruction and forwards them east, so tile i sees the row input i cycles late.
- Products are signed `bw`×`bw`, sign-extended to `psum_bw`. Addition is two's-complement modulo 2^psum_bw unless saturation is compiled in.
- **LOAD:** the first tile with its weight-loaded flag clear captures its activation as its weight and sets the flag. The activation is not forwarded further. Presenting LOAD for `col` cycles fills tiles 0..col-1 with the weights in order.
- **WS EXEC:** `out_s[i] <= in_n[i] + act*weight[i]`, and `valid[i]` is high that cycle.
- **OS EXEC:** `acc[i] <= acc[i] + act*in_n_w[i]`, and `out_s[i] <= in_n[i]` (weight forwarded south). `valid[i]` is high that cycle.
- **CLR:** the tile clears its weight, weight-loaded flag and `acc`.
- **NOP:** `valid[i]` is low and `out_s[i]` holds.
- **Drain FSM (IDLE, DRAIN):**
  - IDLE→DRAIN on `drain_req` when `mode` = 1. `drain_req` is ignored in WS mode and while busy.
  - In DRAIN: `drain_valid` = 1, `drain_data` = `acc[drain_col]`.
  - `drain_col` increments on each `drain_valid && drain_ready`.
  - The handshake at `drain_col` = col-1 clears all `acc` and returns to IDLE.
- While busy, accumulators are frozen:
  - EXEC still forwards weights and asserts `valid`, but does not accumulate.
  - CLR's `acc` clearing is ignored; its weight clearing still applies.
- `mode` is quasi-static. It may change only after `col` NOP cycles with `busy` = 0. Any other change is illegal and the bench must not drive it.

## Timing
- Reset values:
  - `out_s`, `valid`, `drain_data`, `drain_col`, `drain_valid`, `busy` all 0.
  - All weights, flags and `acc` are 0; FSM is IDLE.
- Reset mid-drain aborts the drain immediately; no further words are produced.
- Instruction at row input on edge t produces a result at tile i after edge t+i+1 (`valid[i]` and `out_s[i]` update together).
- `drain_req` sampled at edge t: `busy`, `drain_valid` and `drain_col` = 0 are visible after t+1.
- A full drain takes at least `col` cycles. `busy` falls after the edge of the final handshake.
- With `drain_ready` low, `drain_data` and `drain_col` hold stable.

## Configuration
- `MAC_ROW_SAT_EN` defined: WS psum and OS `acc` additions saturate to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
- Undefined: additions wrap modulo 2^psum_bw.

## Structure
- Package `mac_flex_pkg`:
  - instruction encodings `INST_NOP/LOAD/EXEC/CLR`
  - mode constants `MODE_WS/MODE_OS`
  - drain state enum
  - signed saturating-add function (used only under `MAC_ROW_SAT_EN`)
- Sub-module `mac_tile_flex`: one tile holding weight, flag, acc, forwarding registers and the WS/OS datapath. Its `acc_freeze` input is driven by `busy`.
- The top holds the generate loop, the drain FSM and the `acc` mux.

## Test plan (col=8, bw=4, psum_bw=16)
- WS: LOAD activations 1..7,-1 for 8 cycles, then EXEC act=2 with all `in_n`=10 → `out_s[i]` = 10+2·w[i] (12..24, then 8), `valid[i]` at t+i+1.
- OS: 4 EXEC cycles act=3, weight 2 on every column, then `drain_req` with `drain_ready`=1 → 8 words of 24, `drain_col` 0..7, `busy` low after 8 cycles; a second drain returns 0s.
- Backpressure: drain with `drain_ready` toggling every cycle → each word held stable until accepted, no skips or duplicates.
- Overflow: OS act=7, weight=7 for 700 EXEC cycles → acc = -31236 without `MAC_ROW_SAT_EN`, 32767 with it.
- Reset asserted at `drain_col`=3 → all outputs 0 asynchronously; a subsequent drain yields all 0.
- CLR after WS load, then EXEC act=5, `in_n`=10 → `out_s`=10 (weights cleared); reloading with LOAD works again.
